// File: rtl/conv_post_quant.sv
// Conv post-processing: bias+saturate, ReLU, rounding requantise to 0..127, tagged output stream.
// Latency 3 cycles from in_valid to out_valid (empty FIFO), 1 result/cycle.
// Upstream cannot stall: results arriving at a full FIFO are dropped and flagged on sticky ovf.
module conv_post_quant_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  // Storage is reset so the head never reads as X while empty.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module conv_post_quant #(
  parameter int BIAS_W     = 16,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_W      = 22,
  parameter int OUT_H      = 22,
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic [BIAS_W-1:0] bias,
  input  logic              ovf_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [CW-1:0]     out_col,
  output logic [RW-1:0]     out_row,
  output logic              out_last,
  output logic              ovf
);
  localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H - 1);
  localparam logic [CW-1:0] COL_ONE = 1;
  localparam logic [RW-1:0] ROW_ONE = 1;

  logic [32:0] sum33;
  logic [31:0] sum_sat;
  logic [31:0] s1;
  logic        s1_v;
  logic [32:0] rnd33;
  logic [32:0] shifted;
  logic [7:0]  r;
  logic [7:0]  s2;
  logic        s2_v;
  logic        fifo_empty, fifo_full;
  logic        push, pop, drop;

  always_comb begin
    sum33 = {in_data[31], in_data} + {{(33-BIAS_W){bias[BIAS_W-1]}}, bias};
    sum_sat = sum33[31:0];
    if (sum33[32] != sum33[31]) sum_sat = sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // Rounding add done in 33 bits so a sum near the positive limit cannot wrap.
  always_comb begin
    rnd33   = {1'b0, s1} + (33'd1 << (SHIFT - 1));
    shifted = rnd33 >> SHIFT;
    r       = 8'd0;
    if (!s1[31]) r = (shifted > 33'd127) ? 8'd127 : {1'b0, shifted[6:0]};
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      s1   <= '0;
      s1_v <= 1'b0;
      s2   <= '0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) s1 <= sum_sat;
      s2_v <= s1_v;
      if (s1_v) s2 <= r;
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = s2_v && (!fifo_full || pop);
  assign drop      = s2_v && fifo_full && !pop;

  conv_post_quant_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (push),
    .pop   (pop),
    .wdata (s2),
    .rdata (out_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Position tags follow the head, so they advance only on accepted pops.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      out_col <= '0;
      out_row <= '0;
      ovf     <= 1'b0;
    end else begin
      if (pop) begin
        if (out_col == COL_MAX) begin
          out_col <= '0;
          out_row <= (out_row == ROW_MAX) ? '0 : out_row + ROW_ONE;
        end else begin
          out_col <= out_col + COL_ONE;
        end
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign out_last = (out_col == COL_MAX) && (out_row == ROW_MAX) && out_valid;
endmodule

// File: tb/tb_conv_post_quant.sv
// Directed checks for conv_post_quant with a 3x2 frame so tag wrap is reachable quickly.
module tb_conv_post_quant;
  localparam int OW = 3;
  localparam int OH = 2;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [15:0] bias = '0;
  logic        ovf_clr = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_col;
  logic [0:0]  out_row;
  logic        out_last;
  logic        ovf;

  int total = 0;
  int bad = 0;
  int fr_n;
  bit fr_t;
  logic [1:0] hd_col;
  logic [0:0] hd_row;

  always #5 clk = ~clk;

  conv_post_quant #(.BIAS_W(16), .SHIFT(8), .FIFO_DEPTH(4), .OUT_W(OW), .OUT_H(OH)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .bias      (bias),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_row   (out_row),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_b = 1'b1;
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    out_ready = 1'b0;
    bias = '0;
    repeat (2) tick;
    rst_b = 1'b0;
    tick;
  endtask

  // One sum through an idle pipeline; expects out_valid on the third edge, then pops it.
  task automatic run_one(input string tag, input logic [31:0] d, input logic [15:0] b,
                         input logic [7:0] exp);
    int n;
    bias = b;
    in_data = d;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    hd_col = out_col;
    hd_row = out_row;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_col", 32'(out_col), 32'd0);
    chk("rst_row", 32'(out_row), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    do_reset;

    run_one("single", 32'd1000, 16'd0, 8'd4);
    chk("single_col", 32'(hd_col), 32'd0);
    chk("single_row", 32'(hd_row), 32'd0);
    run_one("bias_rnd", -32'sd200, 16'd328, 8'd1);
    run_one("round_dn", 32'd127, 16'd0, 8'd0);
    run_one("relu", -32'sd5000, 16'd0, 8'd0);
    run_one("sat_pos", 32'h7FFF_FFF0, 16'h7FFF, 8'd127);
    run_one("sat_neg", 32'h8000_0000, 16'hFFFF, 8'd0);

    // Backpressure: six back-to-back sums into a stalled 4-deep FIFO.
    do_reset;
    for (int i = 1; i <= 6; i++) begin
      in_data = 32'(256 * i);
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    chk("bp_ovf_after4", 32'(ovf), 32'd0);
    tick;
    chk("bp_ovf_after5", 32'(ovf), 32'd1);
    repeat (3) tick;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("bp_pop_valid", 32'(out_valid), 32'd1);
      chk("bp_pop_data", 32'(out_data), 32'(i));
      tick;
    end
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("bp_ovf_clr", 32'(ovf), 32'd0);

    // Frame tagging with the consumer toggling out_ready every cycle.
    do_reset;
    fr_n = 0;
    fr_t = 1'b1;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          in_data = 32'(256 * (i + 1));
          in_valid = 1'b1;
          tick;
          in_valid = 1'b0;
          tick;
          tick;
        end
      end
      begin
        for (int c = 0; c < 200 && fr_n < 7; c++) begin
          out_ready = fr_t;
          if (out_valid && out_ready) begin
            chk("frame_data", 32'(out_data), 32'(fr_n + 1));
            chk("frame_col", 32'(out_col), 32'(fr_n % OW));
            chk("frame_row", 32'(out_row), 32'((fr_n / OW) % OH));
            chk("frame_last", 32'(out_last), 32'(fr_n == OW * OH - 1));
            fr_n++;
          end
          fr_t = !fr_t;
          tick;
        end
      end
    join
    chk("frame_count", 32'(fr_n), 32'd7);
    chk("frame_ovf", 32'(ovf), 32'd0);

    // Asynchronous reset with three queued and two in flight.
    do_reset;
    run_one("pre_rst", 32'd1792, 16'd0, 8'd7);
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_data = 32'(256 * i);
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_col", 32'(out_col), 32'd1);
    #3;
    rst_b = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_col", 32'(out_col), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    #2;
    rst_b = 1'b0;
    repeat (6) tick;
    chk("arst_flushed", 32'(out_valid), 32'd0);
    run_one("post_rst", 32'd2304, 16'd0, 8'd9);
    chk("post_rst_col", 32'(hd_col), 32'd0);
    chk("post_rst_row", 32'(hd_row), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_post_quant.md
Name: conv_post_quant

Overview:
- Stage directly downstream of the six-input 32-bit partial-sum adder in the conv path.
- Takes each final signed 32-bit convolution sum and applies bias add with saturation, then ReLU, rounding right-shift requantisation and clamp to 8 bits.
- Buffers results in a small FIFO and emits them on a valid/ready stream with row/column position tags for the feature-map writer.
- The upstream adder cannot stall, so overflow is flagged, not back-pressured.

Parameters:
- BIAS_W, 16, width of signed bias input.
- SHIFT, 8, requantisation right-shift amount (1..16).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2).
- OUT_W, 22, output feature-map width in pixels.
- OUT_H, 22, output feature-map height in pixels.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous, active-high reset. Asserted high clears all state.
- in_valid  in  1  one-cycle qualifier: the upstream sum register updated on the previous edge.
- in_data  in  32  signed convolution sum.
- bias  in  BIAS_W  signed per-channel bias. Held stable for a whole frame.
- ovf_clr  in  1  synchronous clear of the sticky overflow flag.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  8  signed activation, range 0..127.
- out_col  out  clog2(OUT_W)  column index of the head pixel.
- out_row  out  clog2(OUT_H)  row index of the head pixel.
- out_last  out  1  head is the final pixel of the frame.
- ovf  out  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_b=1): pipeline valids=0, FIFO empty, counters=0, out_valid=0, out_data=0, out_col=0, out_row=0, out_last=0, ovf=0.
- Stage 1, edge k, when in_valid=1:
  - s1 = in_data + sign-extended bias, computed in 33 bits.
  - Saturate to signed 32-bit range: 0x7FFFFFFF / 0x80000000.
  - s1_v <= in_valid every cycle.
- Stage 2, edge k+1:
  - If s1 < 0 then r = 0.
  - Else r = (s1 + 2^(SHIFT-1)) >> SHIFT, computed in 33 bits, so no wrap.
  - Clamp r to 127.
  - s2_v <= s1_v.
- FIFO write, edge k+2, when s2_v=1:
  - FIFO not full: push r.
  - FIFO full: drop r and set ovf=1.
  - Full with a pop in the same cycle counts as not full; the push succeeds.
- Latency: in_valid at cycle k gives out_valid=1 from cycle k+3 when the FIFO was empty. Throughput is 1 result per cycle.
- Pop: happens when out_valid & out_ready. out_data is the FIFO head, valid whenever out_valid=1. out_data is don't-care when empty, but must not be X after reset.
- Simultaneous push and pop on an empty FIFO: no bypass. out_valid rises the cycle after the push.
- Position counters advance only on pop:
  - col increments; at col=OUT_W-1 it wraps to 0 and row increments.
  - At row=OUT_H-1 and col=OUT_W-1, both wrap to 0.
  - out_col/out_row reflect the current head.
  - out_last = (col==OUT_W-1) && (row==OUT_H-1) && out_valid.
- ovf:
  - Set has priority over ovf_clr when both occur in the same cycle.
  - Otherwise ovf_clr=1 clears it.
  - Dropped results do not advance the counters.
- out_ready with out_valid=0 has no effect.
- Reset mid-frame: in-flight pipeline data and FIFO contents are discarded and counters return to 0.
- No combinational path from out_ready to out_valid, and none from in_valid to any output.

Test Plan:
- Single sum: bias=0, SHIFT=8, in_data=1000, out_ready=1. Expect out_data=4 at cycle k+3, out_col=0, out_row=0.
- Rounding and bias:
  - in_data=-200, bias=+328 gives 128, so out_data=1.
  - in_data=127 with bias=0 gives out_data=0.
  - in_data=-5000 gives out_data=0 (ReLU).
- Saturation:
  - in_data=0x7FFFFFF0, bias=+0x7FFF: stage-1 sum clamps to 0x7FFFFFFF, out_data=127.
  - in_data=0x80000000, bias=-1: out_data=0.
- Backpressure/overflow: out_ready=0, drive 6 consecutive in_valid with values 256·(1..6).
  - Expect FIFO holds 1,2,3,4 and ovf=1 after the 5th result.
  - Then out_ready=1: expect 4 pops in order, with no 5 or 6.
  - ovf_clr then drops ovf to 0.
- Frame tagging, OUT_W=3, OUT_H=2, 6 results with out_ready toggling 1,0,1,...
  - Expect (col,row) sequence (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - out_last only on (2,1); the next pixel is tagged (0,0).
- Reset mid-stream: assert rst_b=1 asynchronously with 3 entries queued and 2 in flight.
  - Outputs go to reset values immediately.
  - After release, the next in_valid produces output tagged (0,0).
